// File: rtl/multi_phase_signal_controller_if.sv
// Signal bundle between the intersection controller and its environment:
// timebase and sensors in, lamps, phase and pending demand out.
interface multi_phase_signal_controller_if #(
    parameter int NUM_DIR = 4
);
    logic               tick;
    logic [NUM_DIR-1:0] sense;
    logic [NUM_DIR-1:0] red;
    logic [NUM_DIR-1:0] yellow;
    logic [NUM_DIR-1:0] green;
    logic [2:0]         phase;
    logic [NUM_DIR-1:0] req_pend;

    modport master (
        output tick,
        output sense,
        input  red,
        input  yellow,
        input  green,
        input  phase,
        input  req_pend
    );

    modport slave (
        input  tick,
        input  sense,
        output red,
        output yellow,
        output green,
        output phase,
        output req_pend
    );
endinterface

// File: rtl/multi_phase_signal_controller.sv
// Demand-actuated multi-direction traffic signal controller with round-robin
// service, min/max green, yellow and all-red clearance; all outputs registered.
module multi_phase_signal_controller #(
    parameter int NUM_DIR      = 4,
    parameter int CNT_W        = 8,
    parameter int MIN_GREEN    = 3,
    parameter int MAX_GREEN    = 6,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1
) (
    input logic                           clk,
    input logic                           reset,
    multi_phase_signal_controller_if.slave bus
);

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } state_t;

    // Timer comparisons are done one bit wider so timer+1 never wraps.
    localparam logic [CNT_W:0] MIN_G   = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] MAX_G   = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] YEL_T   = (CNT_W+1)'(YELLOW_TIME);
    localparam logic [CNT_W:0] AR_T    = (CNT_W+1)'(ALL_RED_TIME);
    localparam logic [CNT_W:0] ONE_EXT = (CNT_W+1)'(1);

    state_t             state;
    state_t             state_next;
    logic [2:0]         phase_q;
    logic [2:0]         phase_next;
    logic [2:0]         next_dir;
    logic [2:0]         next_dir_next;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_next;
    logic [CNT_W:0]     timer_plus1;
    logic [NUM_DIR-1:0] pend;
    logic [NUM_DIR-1:0] pend_next;
    logic [NUM_DIR-1:0] red_q;
    logic [NUM_DIR-1:0] yellow_q;
    logic [NUM_DIR-1:0] green_q;
    logic [NUM_DIR-1:0] red_d;
    logic [NUM_DIR-1:0] yellow_d;
    logic [NUM_DIR-1:0] green_d;
    logic               sense_phase;
    logic               other_req;
    logic               found;
    logic               recover;
    logic [2:0]         rr_dir;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= GREEN;
            phase_q  <= 3'd0;
            next_dir <= 3'd0;
            timer    <= '0;
            pend     <= '0;
            green_q  <= NUM_DIR'(1);
            yellow_q <= '0;
            red_q    <= ~NUM_DIR'(1);
        end else begin
            state    <= state_next;
            phase_q  <= phase_next;
            next_dir <= next_dir_next;
            timer    <= timer_next;
            pend     <= pend_next;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    always_comb begin
        state_next    = state;
        phase_next    = phase_q;
        next_dir_next = next_dir;
        timer_next    = timer;
        pend_next     = pend;
        sense_phase   = 1'b0;
        other_req     = 1'b0;
        found         = 1'b0;
        recover       = 1'b0;
        rr_dir        = phase_q;
        timer_plus1   = {1'b0, timer} + ONE_EXT;

        for (int i = 0; i < NUM_DIR; i++) begin
            if (phase_q == 3'(i)) begin
                sense_phase = bus.sense[i];
            end else begin
                other_req = other_req | pend[i];
            end
        end

        // Round-robin: nearest pending direction after the current owner.
        for (int k = 1; k < NUM_DIR; k++) begin
            for (int j = 0; j < NUM_DIR; j++) begin
                if (!found && pend[j] && (j == ((int'(phase_q) + k) % NUM_DIR))) begin
                    found  = 1'b1;
                    rr_dir = 3'(j);
                end
            end
        end

        if (bus.tick && !(&timer)) begin
            timer_next = timer_plus1[CNT_W-1:0];
        end

        case (state)
            GREEN: begin
                if (bus.tick && other_req &&
                    (((timer_plus1 >= MIN_G) && !sense_phase) || (timer_plus1 >= MAX_G))) begin
                    state_next    = YELLOW;
                    next_dir_next = rr_dir;
                end
            end
            YELLOW: begin
                if (bus.tick && (timer_plus1 == YEL_T)) begin
                    if (ALL_RED_TIME > 0) begin
                        state_next = ALL_RED;
                    end else begin
                        state_next = GREEN;
                        phase_next = next_dir;
                    end
                end
            end
            ALL_RED: begin
                if (bus.tick && (timer_plus1 == AR_T)) begin
                    state_next = GREEN;
                    phase_next = next_dir;
                end
            end
            default: begin
                recover       = 1'b1;
                state_next    = GREEN;
                phase_next    = 3'd0;
                next_dir_next = 3'd0;
            end
        endcase

        if (state_next != state) begin
            timer_next = '0;
        end

        // Demand is suppressed for the green owner and for a direction entering green.
        for (int i = 0; i < NUM_DIR; i++) begin
            if (((state == GREEN) && (phase_q == 3'(i))) ||
                ((state_next == GREEN) && (phase_next == 3'(i)))) begin
                pend_next[i] = 1'b0;
            end else if (bus.sense[i]) begin
                pend_next[i] = 1'b1;
            end
        end

        if (recover) begin
            pend_next  = '0;
            timer_next = '0;
        end
    end

    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        red_d    = '1;
        for (int i = 0; i < NUM_DIR; i++) begin
            green_d[i]  = (state_next == GREEN)  && (phase_next == 3'(i));
            yellow_d[i] = (state_next == YELLOW) && (phase_next == 3'(i));
            red_d[i]    = !(green_d[i] || yellow_d[i]);
        end
    end

    assign bus.red      = red_q;
    assign bus.yellow   = yellow_q;
    assign bus.green    = green_q;
    assign bus.phase    = phase_q;
    assign bus.req_pend = pend;

endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Scoreboard bench: directed per-cycle vectors push expected lamp/phase/demand
// values; a negedge monitor pops and compares them against the controller.
module tb_multi_phase_signal_controller;

    logic clk;
    logic reset;

    multi_phase_signal_controller_if #(.NUM_DIR(4)) bus ();

    multi_phase_signal_controller #(
        .NUM_DIR(4),
        .CNT_W(8),
        .MIN_GREEN(3),
        .MAX_GREEN(6),
        .YELLOW_TIME(2),
        .ALL_RED_TIME(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] g;
        logic [3:0] y;
        logic [2:0] ph;
        logic [3:0] pend;
        string      name;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs for one cycle plus the outputs expected to be visible during it.
    task automatic applyStimulus(input logic rst, input logic t, input logic [3:0] s,
                                 input logic [3:0] g, input logic [3:0] y,
                                 input logic [2:0] ph, input logic [3:0] pend,
                                 input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        bus.tick  = t;
        bus.sense = s;
        e.g    = g;
        e.y    = y;
        e.ph   = ph;
        e.pend = pend;
        e.name = name;
        expq.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [18:0] act;
        logic [18:0] req;
        int          bad;
        act = {bus.green, bus.yellow, bus.red, bus.phase, bus.req_pend};
        req = {e.g, e.y, ~(e.g | e.y), e.ph, e.pend};
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got g=%b y=%b r=%b ph=%0d pend=%b, want g=%b y=%b r=%b ph=%0d pend=%b",
                     e.name, bus.green, bus.yellow, bus.red, bus.phase, bus.req_pend,
                     e.g, e.y, ~(e.g | e.y), e.ph, e.pend);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if ((32'(bus.red[i]) + 32'(bus.yellow[i]) + 32'(bus.green[i])) != 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL %s_onehot: %0d directions without exactly one lamp, want 0", e.name, bad);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            checkOutput(expq.pop_front());
        end
    end

    initial begin
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.sense = 4'b0000;

        // Reset then rest-in-green with no demand
        applyStimulus(1, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "reset_a");
        applyStimulus(1, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "reset_a");
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "idle_rest");

        // Single request on dir2: min green, yellow, all-red, then dir2 green
        applyStimulus(1, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "reset_b");
        applyStimulus(0, 1, 4'b0100, 4'b0001, 4'b0000, 3'd0, 4'b0000, "b_green0");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0100, "b_green1");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0100, "b_green2");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0100, "b_yellow0");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0100, "b_yellow1");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0100, "b_allred");
        applyStimulus(0, 1, 4'b0000, 4'b0100, 4'b0000, 3'd2, 4'b0000, "b_dir2_green");
        applyStimulus(0, 1, 4'b0000, 4'b0100, 4'b0000, 3'd2, 4'b0000, "b_dir2_rest");

        // Dir0 demand held plus dir1 request: max-out after 6 green ticks
        applyStimulus(1, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "reset_c");
        applyStimulus(0, 1, 4'b0011, 4'b0001, 4'b0000, 3'd0, 4'b0000, "c_green0");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 4'b0001, 4'b0001, 4'b0000, 3'd0, 4'b0010, "c_green_ext");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0010, "c_yellow0");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0010, "c_yellow1");
        applyStimulus(0, 1, 4'b0010, 4'b0000, 4'b0000, 3'd0, 4'b0010, "c_allred_sense");
        applyStimulus(0, 1, 4'b1001, 4'b0010, 4'b0000, 3'd1, 4'b0000, "c_dir1_entry");

        // Round-robin from dir1 with demand on dirs 0 and 3: dir3 then dir0
        applyStimulus(0, 1, 4'b0000, 4'b0010, 4'b0000, 3'd1, 4'b1001, "d_green1");
        applyStimulus(0, 1, 4'b0000, 4'b0010, 4'b0000, 3'd1, 4'b1001, "d_green2");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0010, 3'd1, 4'b1001, "d_yellow0");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0010, 3'd1, 4'b1001, "d_yellow1");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0000, 3'd1, 4'b1001, "d_allred");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 4'b0000, 4'b1000, 4'b0000, 3'd3, 4'b0001, "d_dir3_green");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b1000, 3'd3, 4'b0001, "d_dir3_yellow");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b1000, 3'd3, 4'b0001, "d_dir3_yellow");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0000, 3'd3, 4'b0001, "d_allred2");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "d_dir0_green");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "d_dir0_rest");

        // Tick freeze during yellow, demand still latched, async reset in all-red
        applyStimulus(1, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "reset_e");
        applyStimulus(0, 1, 4'b0010, 4'b0001, 4'b0000, 3'd0, 4'b0000, "e_green0");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0010, "e_green1");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0010, "e_green2");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0010, "e_yellow_tick");
        applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0010, "e_yellow_frozen");
        applyStimulus(0, 0, 4'b0100, 4'b0000, 4'b0001, 3'd0, 4'b0010, "e_yellow_frozen");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0110, "e_yellow_latch");
        applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0110, "e_yellow_resume");
        applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0110, "e_allred_hold");
        applyStimulus(1, 0, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "e_async_reset");
        applyStimulus(0, 1, 4'b0000, 4'b0001, 4'b0000, 3'd0, 4'b0000, "e_after_reset");

        for (int i = 0; i < 8 && expq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expected entries left, want 0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_phase_signal_controller.md
MULTI_PHASE_SIGNAL_CONTROLLER -- requirements
Module: multi_phase_signal_controller

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4, number of directions served; legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 8, phase timer width in bits.
REQ-003 SHALL have parameter MIN_GREEN, default 3, minimum green duration in ticks; legal range 1..2^CNT_W-1.
REQ-004 SHALL have parameter MAX_GREEN, default 6, maximum green duration in ticks under competing demand; legal range MIN_GREEN..2^CNT_W-1.
REQ-005 SHALL have parameter YELLOW_TIME, default 2, yellow duration in ticks; legal range 1..2^CNT_W-1.
REQ-006 SHALL have parameter ALL_RED_TIME, default 1, all-red clearance in ticks; 0 skips clearance.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 tick  input  1  timebase enable; timers advance only on cycles with tick=1.
REQ-010 sense  input  NUM_DIR  per-direction vehicle sensor, bit i = direction i, synchronous to clk.
REQ-011 red  output  NUM_DIR  red lamp per direction.
REQ-012 yellow  output  NUM_DIR  yellow lamp per direction.
REQ-013 green  output  NUM_DIR  green lamp per direction.
REQ-014 phase  output  3  index of the direction currently owning green/yellow (or last owner during all-red).
REQ-015 req_pend  output  NUM_DIR  latched demand register.

Function
REQ-016 SHALL implement FSM states GREEN, YELLOW, ALL_RED; all outputs driven from registers, no combinational input-to-output path.
REQ-017 Per direction i, exactly one of red[i], yellow[i], green[i] SHALL be 1 every cycle; green[phase]=1 only in GREEN, yellow[phase]=1 only in YELLOW, all other bits red.
REQ-018 Phase timer SHALL clear to 0 on every state entry, increment on tick cycles, and saturate at 2^CNT_W-1.
REQ-019 req_pend[i] SHALL set on any cycle sense[i]=1 and i is not in GREEN; req_pend[phase] SHALL be held 0 while in GREEN.
REQ-020 other_req = OR of req_pend excluding bit phase.
REQ-021 GREEN SHALL exit to YELLOW on a tick cycle when other_req=1 and either (timer+1>=MIN_GREEN and sense[phase]=0) or timer+1>=MAX_GREEN.
REQ-022 GREEN with other_req=0 SHALL hold indefinitely (rest-in-green), irrespective of timer.
REQ-023 On GREEN->YELLOW transition, next direction SHALL be latched: first i with req_pend[i]=1 searching phase+1, phase+2, ... modulo NUM_DIR (round-robin).
REQ-024 YELLOW SHALL exit on the tick cycle where timer+1==YELLOW_TIME; to ALL_RED if ALL_RED_TIME>0, else directly to GREEN.
REQ-025 ALL_RED SHALL exit to GREEN on the tick cycle where timer+1==ALL_RED_TIME.
REQ-026 phase SHALL update to latched next direction on entry to GREEN, and req_pend of that direction SHALL clear in the same edge.
REQ-027 Sensor assertion on the same cycle a direction enters GREEN SHALL NOT leave req_pend set for that direction.
REQ-028 tick=0 SHALL freeze timer and all timed transitions; req_pend latching continues.
REQ-029 Unreachable FSM encoding SHALL recover to reset state on next edge.

Reset
REQ-030 On reset assertion, immediately and while held: state=GREEN, phase=0, timer=0, req_pend=0, green=0...01, yellow=0, red=all ones except bit 0.
REQ-031 Reset asserted mid-YELLOW or mid-ALL_RED SHALL abort the sequence and return to REQ-030 values without intermediate outputs.

Verification (NUM_DIR=4, MIN_GREEN=3, MAX_GREEN=6, YELLOW_TIME=2, ALL_RED_TIME=1, tick every cycle unless stated)
REQ-032 Reset, no sense for 20 cycles -> green=0001, phase=0 throughout, req_pend=0.
REQ-033 After reset pulse sense[2] one cycle -> req_pend=0100; green dir0 for 3 cycles total, yellow[0] 2 cycles, all red 1 cycle, then green=0100, phase=2, req_pend=0000.
REQ-034 sense[0] held high plus req on dir1 -> dir0 green extends to exactly 6 ticks (max-out), then yellow[0].
REQ-035 Phase 1 green, req_pend=1001 -> next green is dir3 (round-robin from 2), then dir0.
REQ-036 tick low for 10 cycles during YELLOW -> yellow held, timer frozen, transition resumes after 1 further tick; reset asserted in ALL_RED -> green=0001 asynchronously.
